wave_gen: RTL and testbench



---
 rtl/wave_gen_pkg.sv | 39 +++
 rtl/wave_sine_lut.sv | 45 ++++
 rtl/wave_gen.sv | 115 +++++++++++
 tb/tb_wave_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/wave_gen_pkg.sv
// Shared mode encodings, DAC constants and sample helpers for wave_gen.
// scale_sample() is only instantiated when WAVE_GEN_AMP_EN is defined.
package wave_gen_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'b00,
    WAVE_SQUARE = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_SAW    = 2'b11
  } wave_mode_e;

  localparam logic [7:0] DAC_MID   = 8'd128;
  localparam logic [7:0] DAC_FULL  = 8'd255;
  localparam logic [7:0] DAC_ZERO  = 8'd0;
  localparam int         PHASE_TOP = 255;

  function automatic logic [7:0] square_sample(input logic [7:0] p);
    return p[7] ? DAC_ZERO : DAC_FULL;
  endfunction

  // 511-2p on the falling half equals the bitwise complement of 2p mod 256.
  function automatic logic [7:0] tri_sample(input logic [7:0] p);
    logic [7:0] up;
    up = {p[6:0], 1'b0};
    return p[7] ? ~up : up;
  endfunction

  // Gain is amp+1 (1..16), kept in 6 signed bits so 16 stays positive.
  function automatic logic [7:0] scale_sample(input logic [7:0] s, input logic [3:0] amp);
    logic signed [8:0]  diff;
    logic signed [5:0]  gain;
    logic signed [14:0] prod;
    diff = $signed({1'b0, s}) - 9'sd128;
    gain = $signed({2'b00, amp}) + 6'sd1;
    prod = 15'(diff) * 15'(gain);
    return 8'(prod >>> 4) + DAC_MID;
  endfunction

endpackage

// File: rtl/wave_sine_lut.sv
// Combinational sine sample: 128 + round(127*sin(2*pi*p/256)), from a
// quarter-wave table folded by phase[7:6].
module wave_sine_lut
  import wave_gen_pkg::*;
(
  input  logic [7:0] phase_i,
  output logic [7:0] sample_o
);

  logic [6:0] idx;
  logic [6:0] mag;

  function automatic logic [6:0] quarter(input logic [6:0] k);
    logic [6:0] v;
    case (k)
      7'd0:  v = 7'd0;   7'd1:  v = 7'd3;   7'd2:  v = 7'd6;   7'd3:  v = 7'd9;
      7'd4:  v = 7'd12;  7'd5:  v = 7'd16;  7'd6:  v = 7'd19;  7'd7:  v = 7'd22;
      7'd8:  v = 7'd25;  7'd9:  v = 7'd28;  7'd10: v = 7'd31;  7'd11: v = 7'd34;
      7'd12: v = 7'd37;  7'd13: v = 7'd40;  7'd14: v = 7'd43;  7'd15: v = 7'd46;
      7'd16: v = 7'd49;  7'd17: v = 7'd51;  7'd18: v = 7'd54;  7'd19: v = 7'd57;
      7'd20: v = 7'd60;  7'd21: v = 7'd63;  7'd22: v = 7'd65;  7'd23: v = 7'd68;
      7'd24: v = 7'd71;  7'd25: v = 7'd73;  7'd26: v = 7'd76;  7'd27: v = 7'd78;
      7'd28: v = 7'd81;  7'd29: v = 7'd83;  7'd30: v = 7'd85;  7'd31: v = 7'd88;
      7'd32: v = 7'd90;  7'd33: v = 7'd92;  7'd34: v = 7'd94;  7'd35: v = 7'd96;
      7'd36: v = 7'd98;  7'd37: v = 7'd100; 7'd38: v = 7'd102; 7'd39: v = 7'd104;
      7'd40: v = 7'd106; 7'd41: v = 7'd107; 7'd42: v = 7'd109; 7'd43: v = 7'd111;
      7'd44: v = 7'd112; 7'd45: v = 7'd113; 7'd46: v = 7'd115; 7'd47: v = 7'd116;
      7'd48: v = 7'd117; 7'd49: v = 7'd118; 7'd50: v = 7'd120; 7'd51: v = 7'd121;
      7'd52: v = 7'd122; 7'd53: v = 7'd122; 7'd54: v = 7'd123; 7'd55: v = 7'd124;
      7'd56: v = 7'd125; 7'd57: v = 7'd125; 7'd58: v = 7'd126; 7'd59: v = 7'd126;
      7'd60: v = 7'd126; 7'd61: v = 7'd127; 7'd62: v = 7'd127; 7'd63: v = 7'd127;
      7'd64: v = 7'd127;
      default: v = 7'd0;
    endcase
    return v;
  endfunction

  // Odd quadrants mirror the index; the upper half mirrors about mid-scale.
  always_comb begin
    idx      = phase_i[6] ? (7'd64 - {1'b0, phase_i[5:0]}) : {1'b0, phase_i[5:0]};
    mag      = quarter(idx);
    sample_o = phase_i[7] ? (DAC_MID - {1'b0, mag}) : (DAC_MID + {1'b0, mag});
  end

endmodule

// File: rtl/wave_gen.sv
// Phase-stepped waveform generator feeding the DAC interface stage.
// Optional WAVE_GEN_AMP_EN adds an amp port and a scaling register stage.
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int PHASE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               memclk,
  input  logic [1:0]         memmode,
`ifdef WAVE_GEN_AMP_EN
  input  logic [3:0]         amp,
`endif
  output logic [PHASE_W-1:0] phase,
  output logic [7:0]         dac_data,
  output logic               dac_valid,
  output logic [1:0]         active_mode
);

  logic               memclk_dly_q;
  logic               step;
  logic [PHASE_W-1:0] phase_q, phase_d;
  wave_mode_e         mode_q, mode_d;
  logic               step_q;
  logic [7:0]         sine_s;
  logic [7:0]         sample;
  logic [7:0]         dac_data_q;
  logic               dac_valid_q;

  assign step = memclk & ~memclk_dly_q;

  // Mode only changes on the step that wraps the phase, so periods never mix shapes.
  always_comb begin
    phase_d = phase_q;
    mode_d  = mode_q;
    if (step) begin
      phase_d = phase_q + 1'b1;
      if (phase_q == PHASE_W'(PHASE_TOP)) begin
        mode_d = wave_mode_e'(memmode);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memclk_dly_q <= 1'b0;
      phase_q      <= '0;
      mode_q       <= WAVE_SINE;
      step_q       <= 1'b0;
    end else begin
      memclk_dly_q <= memclk;
      phase_q      <= phase_d;
      mode_q       <= mode_d;
      step_q       <= step;
    end
  end

  wave_sine_lut u_sine (
    .phase_i  (phase_q),
    .sample_o (sine_s)
  );

  always_comb begin
    sample = DAC_MID;
    case (mode_q)
      WAVE_SINE:   sample = sine_s;
      WAVE_SQUARE: sample = square_sample(phase_q);
      WAVE_TRI:    sample = tri_sample(phase_q);
      WAVE_SAW:    sample = phase_q;
      default:     sample = DAC_MID;
    endcase
  end

`ifdef WAVE_GEN_AMP_EN
  logic [7:0] raw_q;
  logic       raw_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q       <= DAC_MID;
      raw_vld_q   <= 1'b0;
      dac_data_q  <= DAC_MID;
      dac_valid_q <= 1'b0;
    end else begin
      raw_vld_q   <= step_q;
      dac_valid_q <= raw_vld_q;
      if (step_q) begin
        raw_q <= sample;
      end
      if (raw_vld_q) begin
        dac_data_q <= scale_sample(raw_q, amp);
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_data_q  <= DAC_MID;
      dac_valid_q <= 1'b0;
    end else begin
      dac_valid_q <= step_q;
      if (step_q) begin
        dac_data_q <= sample;
      end
    end
  end
`endif

  assign phase       = phase_q;
  assign dac_data    = dac_data_q;
  assign dac_valid   = dac_valid_q;
  assign active_mode = mode_q;

endmodule

// File: tb/tb_wave_gen.sv
// Scoreboard bench for wave_gen: each driven step pushes its expected sample,
// the output monitor pops and compares on every dac_valid.
module tb_wave_gen;
  import wave_gen_pkg::*;

`ifdef WAVE_GEN_AMP_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam real PI = 3.141592653589793;

  logic       clk;
  logic       rst_n;
  logic       memclk;
  logic [1:0] memmode;
  logic [3:0] amp;
  logic [7:0] phase;
  logic [7:0] dac_data;
  logic       dac_valid;
  logic [1:0] active_mode;

  wave_gen #(.PHASE_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .memclk      (memclk),
    .memmode     (memmode),
`ifdef WAVE_GEN_AMP_EN
    .amp         (amp),
`endif
    .phase       (phase),
    .dac_data    (dac_data),
    .dac_valid   (dac_valid),
    .active_mode (active_mode)
  );

  typedef struct {
    int data;
    int due;
    int mode;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   m_phase;
  int   m_mode;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_sine(input int p);
    real v;
    int  r;
    v = 127.0 * $sin(2.0 * PI * p / 256.0);
    if (v >= 0.0) r = int'($floor(v + 0.5));
    else          r = -int'($floor(-v + 0.5));
    return 128 + r;
  endfunction

  function automatic int model_sample(input int mode, input int p);
    case (mode)
      0:       return model_sine(p);
      1:       return (p < 128) ? 255 : 0;
      2:       return (p < 128) ? 2 * p : 511 - 2 * p;
      default: return p;
    endcase
  endfunction

  function automatic int model_out(input int s, input int a);
`ifdef WAVE_GEN_AMP_EN
    int prod;
    prod = (s - 128) * (a + 1);
    return 128 + (prod >>> 4);
`else
    if (a < 0) return -1;
    return s;
`endif
  endfunction

  function automatic exp_t model_step(input int mode_in);
    exp_t e;
    m_phase = (m_phase + 1) % 256;
    if (m_phase == 0) m_mode = mode_in;
    e.data = model_out(model_sample(m_mode, m_phase), int'(amp));
    e.due  = cyc + LAT;
    e.mode = m_mode;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && dac_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("dac_data", int'(dac_data), mon_e.data);
        check("latency", cyc, mon_e.due);
        check("active_mode", int'(active_mode), mon_e.mode);
      end
    end
  end

  task automatic do_pulse(input int hold, input int gap);
    @(negedge clk);
    memclk = 1'b1;
    sb.push_back(model_step(int'(memmode)));
    repeat (hold) @(negedge clk);
    memclk = 1'b0;
    repeat (gap) @(negedge clk);
    check("phase", int'(phase), m_phase);
  endtask

  task automatic run_to(input int p);
    do_pulse(1, 3);
    while (m_phase != p) do_pulse(1, 3);
  endtask

  task automatic do_reset(input bit hold_high);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_phase", int'(phase), 0);
    check("rst_dac_data", int'(dac_data), 128);
    check("rst_dac_valid", int'(dac_valid), 0);
    check("rst_active_mode", int'(active_mode), 0);
    memclk = hold_high;
    sb.delete();
    m_phase = 0;
    m_mode  = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    if (hold_high) sb.push_back(model_step(int'(memmode)));
  endtask

  initial begin
    rst_n   = 1'b0;
    memclk  = 1'b0;
    memmode = 2'b00;
    amp     = 4'd15;
    m_phase = 0;
    m_mode  = 0;

    do_reset(1'b0);

    do_pulse(5, 3);
    check("sine_p1", int'(dac_data), 131);

    run_to(64);
    check("sine_p64", int'(dac_data), 255);
    run_to(192);
    check("sine_p192", int'(dac_data), 1);
    run_to(0);
    check("sine_wrap", int'(dac_data), 128);

    run_to(100);
    memmode = 2'b10;
    run_to(255);
    check("mode_held", int'(active_mode), 0);
    run_to(0);
    check("tri_p0", int'(dac_data), 0);
    check("tri_mode", int'(active_mode), 2);
    run_to(128);
    check("tri_p128", int'(dac_data), 255);

    memmode = 2'b01;
    run_to(0);
    run_to(127);
    check("sq_p127", int'(dac_data), 255);
    do_pulse(1, 3);
    check("sq_p128", int'(dac_data), 0);

    memmode = 2'b11;
    run_to(0);
    run_to(127);
    check("saw_p127", int'(dac_data), 127);
    do_pulse(1, 3);
    check("saw_p128", int'(dac_data), 128);

    for (int i = 0; i < 8; i++) do_pulse(1, 0);
    do_pulse(1, 3);

    run_to(77);
    do_reset(1'b1);
    repeat (4) @(negedge clk);
    memclk = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_phase", int'(phase), 1);
    check("post_rst_data", int'(dac_data), 131);
    check("post_rst_mode", int'(active_mode), 0);

`ifdef WAVE_GEN_AMP_EN
    memmode = 2'b00;
    do_reset(1'b0);
    amp = 4'd7;
    run_to(64);
    check("amp7_p64", int'(dac_data), 191);
    do_reset(1'b0);
    amp = 4'd0;
    run_to(64);
    check("amp0_p64", int'(dac_data), 135);
    run_to(192);
    check("amp0_p192", int'(dac_data), 120);
    amp = 4'd15;
`endif

    repeat (6) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
